// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction-fetch unit with a DEPTH-entry prefetch queue.
// Streams sequential words from the instruction bus ahead of decode and
// buffers each word with its PC. A redirect flushes the queue and restarts
// fetch at the new PC. Only one bus request is ever outstanding.
//
// Ports
//   clock, reset        rising-edge clock, async active-low reset
//   io_reqValid/io_addr bus request (held until io_respValid), word address
//   io_respValid/rdata  one-cycle bus response with instruction word
//   respValid/inst/pc   queue head towards IDU (combinational head read)
//   reqValid            IDU pops the head when respValid=1
//   redirect/_pc        one-cycle flush-and-restart, pc[1:0] ignored
//   count               queue occupancy 0..DEPTH
//   is_ifu_wait         IDU wants an instruction but the queue is empty
module ifu_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     io_reqValid,
  output logic [31:0]              io_addr,
  input  logic                     io_respValid,
  input  logic [31:0]              io_rdata,
  output logic                     respValid,
  input  logic                     reqValid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     is_ifu_wait
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic        push, pop, full;
  logic [31:0] redir_pc;

  assign full      = (count == FULL_CNT);
  assign respValid = (count != '0);
  assign pop       = respValid & reqValid;
  // A response racing a redirect belongs to the old stream: never pushed.
  assign push      = (state == WAIT) & io_respValid & ~redirect;
  assign redir_pc  = {redirect_pc[31:2], 2'b00};

  assign inst    = inst_mem[rd_ptr];
  assign inst_pc = pc_mem[rd_ptr];
  // Gated by reset so the stall counter sees 0 while the block is held.
  assign is_ifu_wait = reset & reqValid & ~respValid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      io_reqValid <= 1'b0;
      io_addr     <= RESET_PC;
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= io_addr;
        inst_mem[wr_ptr] <= io_rdata;
        wr_ptr           <= wr_ptr + AW'(1);
      end

      if (redirect) begin
        // Flush wins over a same-cycle pop; the popped head counts as delivered.
        count    <= '0;
        rd_ptr   <= wr_ptr;
        fetch_pc <= redir_pc;
        case (state)
          // No request on the bus: present the new address right away.
          IDLE: io_addr <= redir_pc;
          WAIT, DROP: begin
            if (io_respValid) begin
              io_reqValid <= 1'b0;
              state       <= IDLE;
            end else begin
              // Let the bus transaction finish, then throw its data away.
              state <= DROP;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: ;
        endcase

        case (state)
          IDLE: begin
            // Issuing only below full guarantees the later push has room.
            if (!full) begin
              io_reqValid <= 1'b1;
              io_addr     <= fetch_pc;
              state       <= WAIT;
            end
          end
          WAIT: begin
            if (io_respValid) begin
              fetch_pc    <= io_addr + 32'd4;
              io_reqValid <= 1'b0;
              state       <= IDLE;
            end
          end
          DROP: begin
            if (io_respValid) begin
              io_reqValid <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Testbench for ifu_prefetch: randomized bus latency / pops / redirects
// checked every cycle against a queue-level behavioural model, plus
// directed scenarios with hand-computed expectations.
module tb_ifu_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_reqValid;
  logic [31:0] io_addr;
  logic        io_respValid;
  logic [31:0] io_rdata;
  logic        respValid;
  logic        reqValid;
  logic [31:0] inst, inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic        is_ifu_wait;

  ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .io_reqValid(io_reqValid), .io_addr(io_addr),
    .io_respValid(io_respValid), .io_rdata(io_rdata),
    .respValid(respValid), .reqValid(reqValid),
    .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .count(count), .is_ifu_wait(is_ifu_wait)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic        m_req, m_disc;
  logic [31:0] m_addr, m_fpc;
  int          m_sz;

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      mq.delete(); m_req = 0; m_disc = 0; m_addr = RESET_PC; m_fpc = RESET_PC;
    end else begin
      m_sz = mq.size();
      if (redirect) begin
        mq.delete();
        m_fpc = redirect_pc & ~32'h3;
        if (!m_req) m_addr = m_fpc;
        else if (io_respValid) begin m_req = 0; m_disc = 0; end
        else m_disc = 1;
      end else begin
        if (m_sz > 0 && reqValid) void'(mq.pop_front());
        if (m_req) begin
          if (io_respValid) begin
            if (!m_disc) begin
              mq.push_back('{pc: m_addr, ins: io_rdata});
              m_fpc = m_addr + 32'd4;
            end
            m_req = 0; m_disc = 0;
          end
        end else if (m_sz < DEPTH) begin
          m_req = 1; m_addr = m_fpc;
        end
      end
    end
  end

  // ---------------- compare + logging ----------------
  logic [31:0] reqs[$];
  logic [31:0] pops[$];
  logic        prev_req = 0;

  initial forever begin
    @(negedge clock);
    if (!reset) prev_req = 0;
    else begin
      chk("io_reqValid", io_reqValid, m_req);
      chk("io_addr", io_addr, m_addr);
      chk("respValid", respValid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("is_ifu_wait", is_ifu_wait, reqValid && mq.size() == 0);
      if (mq.size() != 0) begin
        chk("inst", inst, mq[0].ins);
        chk("inst_pc", inst_pc, mq[0].pc);
      end
      if (respValid && reqValid) pops.push_back(inst_pc);
      if (io_reqValid && !prev_req) reqs.push_back(io_addr);
      prev_req = io_reqValid;
    end
  end

  // ---------------- bus responder ----------------
  int   lat_lo = 2, lat_hi = 2;
  int   cnt = 0;
  logic busy = 0;
  logic stray = 0;

  initial begin
    io_respValid = 0; io_rdata = 0;
    forever begin
      @(posedge clock); #1;
      if (io_respValid) begin io_respValid = 0; busy = 0; end
      if (stray) begin
        io_respValid = 1; io_rdata = 32'hBAD0_BAD0; stray = 0; busy = 0;
      end else if (!reset) busy = 0;
      else if (busy) begin
        if (cnt <= 1) begin io_respValid = 1; io_rdata = mk(io_addr); end
        else cnt--;
      end else if (io_reqValid) begin
        busy = 1; cnt = $urandom_range(lat_hi, lat_lo);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic timeout(input string nm);
    n_vec++; n_err++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int k, n_wait;
    reset = 0; reqValid = 1; redirect = 0; redirect_pc = 0;
    repeat (3) @(posedge clock); #2;
    chk("rst io_reqValid", io_reqValid, 0);
    chk("rst io_addr", io_addr, RESET_PC);
    chk("rst respValid", respValid, 0);
    chk("rst count", count, 0);
    chk("rst inst", inst, 0);
    chk("rst inst_pc", inst_pc, 0);
    chk("rst is_ifu_wait", is_ifu_wait, 0);
    reqValid = 0;
    reset = 1;
    tick();
    chk("first req valid", io_reqValid, 1);
    chk("first req addr", io_addr, RESET_PC);

    // Reset then fill
    k = 0;
    while (count != 4 && k < 200) begin tick(); k++; end
    if (k >= 200) timeout("fill");
    repeat (8) tick();
    chk("fill count", count, 4);
    chk("fill idle bus", io_reqValid, 0);
    chk("fill nreq", reqs.size(), 4);
    for (int i = 0; i < 4 && i < reqs.size(); i++)
      chk("fill req addr", reqs[i], RESET_PC + 32'(4*i));

    // Drain and refill
    pops.delete();
    reqValid = 1;
    repeat (60) tick();
    reqValid = 0;
    chk("drain enough", pops.size() >= 8, 1);
    for (int i = 0; i < 12 && i < pops.size(); i++)
      chk("drain order", pops[i], RESET_PC + 32'(4*i));

    // Reset mid-operation with a stray late response
    redirect = 1; redirect_pc = RESET_PC + 32'h200; tick(); redirect = 0;
    k = 0;
    while (!(count == 2 && io_reqValid) && k < 200) begin tick(); k++; end
    if (k >= 200) timeout("reach count2 wait");
    reqValid = 1;
    reset = 0; stray = 1; reqs.delete();
    #1;
    chk("mid rst io_reqValid", io_reqValid, 0);
    chk("mid rst io_addr", io_addr, RESET_PC);
    chk("mid rst respValid", respValid, 0);
    chk("mid rst count", count, 0);
    chk("mid rst inst_pc", inst_pc, 0);
    chk("mid rst is_ifu_wait", is_ifu_wait, 0);
    reqValid = 0;
    tick();
    reset = 1;
    tick();
    chk("restart valid", io_reqValid, 1);
    chk("restart addr", io_addr, RESET_PC);
    chk("stray ignored", count, 0);

    // Redirect while waiting for RESET_PC+8
    k = 0;
    while (!(io_reqValid && io_addr == RESET_PC + 32'h8) && k < 200) begin tick(); k++; end
    if (k >= 200) timeout("reach wait +8");
    redirect = 1; redirect_pc = RESET_PC + 32'h102; tick(); redirect = 0;
    k = 0;
    while (reqs.size() < 4 && k < 200) begin tick(); k++; end
    if (k >= 200) timeout("redirect req");
    else chk("redirect next addr", reqs[3], RESET_PC + 32'h100);
    pops.delete(); reqValid = 1;
    k = 0;
    while (pops.size() < 1 && k < 200) begin tick(); k++; end
    if (k >= 200) timeout("redirect head");
    else chk("redirect head pc", pops[0], RESET_PC + 32'h100);
    reqValid = 0;

    // Redirect in the same cycle as a response
    k = 0;
    while (!io_respValid && k < 200) begin tick(); k++; end
    if (k >= 200) timeout("resp for redirect");
    redirect = 1; redirect_pc = RESET_PC + 32'h401; tick(); redirect = 0;
    @(negedge clock);
    chk("sim redir count", count, 0);
    chk("sim redir respValid", respValid, 0);
    chk("sim redir bus idle", io_reqValid, 0);
    tick();
    chk("sim redir reissue", io_reqValid, 1);
    chk("sim redir addr", io_addr, RESET_PC + 32'h400);

    // Push and pop together at count=3
    k = 0;
    while (!(io_respValid && count == 3) && k < 200) begin tick(); k++; end
    if (k >= 200) timeout("reach count3 push");
    reqValid = 1;
    @(negedge clock);
    chk("push+pop count", count, 3);
    tick();

    // is_ifu_wait while the queue is empty
    lat_lo = 4; lat_hi = 4;
    k = 0;
    while (io_reqValid && k < 200) begin tick(); k++; end
    if (k >= 200) timeout("reach idle");
    redirect = 1; redirect_pc = RESET_PC + 32'h800; tick(); redirect = 0;
    n_wait = 0;
    k = 0;
    while (k < 50) begin
      @(negedge clock);
      if (respValid) break;
      chk("wait flag high", is_ifu_wait, 1);
      n_wait++; k++;
    end
    chk("wait flag clears", is_ifu_wait, 0);
    chk("wait cycles", n_wait, 6);
    tick();

    // Randomized traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 500; i++) begin
      reqValid = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 31) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF5 : $urandom;
      tick();
    end
    redirect = 0; reqValid = 0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
